bus_wrr_scheduler: RTL and testbench
====================================

# bus_wrr_scheduler

Weighted round-robin scheduler that sits between the `drvrs` source FIFOs and the shared bus datapath. It chooses which pending driver owns the bus and pops that driver's FIFO. It then holds the packet on a valid/ready bus port until the datapath accepts it. A per-driver weight sets how many back-to-back packets a driver may send before ownership rotates.

## Interface
- `drvrs`, 8: number of source drivers; must be ≥ 2.
- `pckg_sz`, 16: packet width in bits.
- `wgt_w`, 4: width of each per-driver weight field.
- `starve_lim`, 64: wait-cycle threshold for starvation override; used only with `WRR_STARVE_EN`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `pndng` in `drvrs`: FIFO non-empty flags, one per driver.
- `D_pop` in `drvrs`×`pckg_sz`: show-ahead FIFO head data, one word per driver.
- `weight` in `drvrs*wgt_w`: packed weights; driver i uses bits [i*wgt_w +: wgt_w]. Sampled at grant time.
- `pop` out `drvrs`: one-hot FIFO pop strobe, registered.
- `bus_data` out `pckg_sz`: captured packet.
- `bus_src` out `$clog2(drvrs)`: index of the driver that sourced `bus_data`.
- `bus_vld` out 1: packet valid toward the datapath.
- `bus_rdy` in 1: datapath accept.
- `busy` out 1: high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, POP, SEND.
- IDLE:
  - If `pndng` is zero, stay in IDLE.
  - Otherwise choose winner `w`: the first set bit of `pndng`, searching circularly from pointer `ptr`.
  - Register `w`, load `credit = max(weight[w], 1)`, and go to POP.
- POP:
  - `pop[w]=1` for exactly one cycle.
  - Capture `bus_data <= D_pop[w]` and `bus_src <= w` at the end of this cycle.
  - Go to SEND.
- SEND:
  - `bus_vld=1`. `bus_data` and `bus_src` stay stable until `bus_vld && bus_rdy`.
  - On handshake, `credit` decrements.
  - If `credit` after the decrement is > 0 and `pndng[w]=1`, go to POP with the same `w` (burst).
  - Otherwise set `ptr <= (w+1) mod drvrs` and go to IDLE.
- `pndng` sampled in SEND already reflects the POP-cycle pop, because the FIFO updates by then.
- A weight value of 0 is treated as 1. The credit counter is `wgt_w` bits wide and never underflows.
- The scheduler never pops a driver whose `pndng` is low. During a burst, a dropped `pndng[w]` ends the burst early.
- `bus_rdy` is ignored outside SEND.

## Timing
- Reset values:
  - state=IDLE, `pop`=0, `bus_vld`=0, `busy`=0.
  - `bus_data`=0, `bus_src`=0, `ptr`=0, `credit`=0, starvation counters=0.
- Reset mid-operation: a packet captured but not yet accepted is dropped. An asserted `pop` deasserts in the next cycle.
- Latency: `pndng` seen in IDLE at cycle N → `pop` at N+1 → `bus_vld` at N+2.
- Single-packet grant with `bus_rdy=1`: 3 cycles per packet.
- Burst throughput: 1 packet per 2 cycles (SEND→POP→SEND).
- Back-pressure: SEND holds for any number of cycles while `bus_rdy`=0. No further pop occurs during the hold.

## Configuration
- `WRR_STARVE_EN` defined:
  - Each driver i has a wait counter, `$clog2(starve_lim+1)` bits, saturating at `starve_lim`.
  - The counter increments each cycle that `pndng[i]=1` and i is not the current `w`. It clears when i is granted, or when `pndng[i]=0`.
  - In IDLE, if any counter equals `starve_lim`, the lowest-index starving driver wins regardless of `ptr`, and its credit is forced to 1 (no burst). `ptr` still advances to winner+1.
  - In SEND, a handshake ends the burst if any other driver's counter equals `starve_lim`.
- `WRR_STARVE_EN` undefined:
  - No counters are built. Pure weighted round-robin as above.

## Test plan
- Reset, then `pndng`=8'h04 with 1 packet on driver 2, `bus_rdy`=1 → `pop`=8'h04 in cycle 1, `bus_vld` in cycle 2 with `bus_src`=2 and `bus_data`=D_pop[2]; state returns to IDLE and `ptr`=3.
- All 8 drivers always pending, all weights 1, `bus_rdy`=1 → `bus_src` sequence is 0,1,…,7,0, one packet per 3 cycles.
- Weights {d0=3, others 1}, d0 and d1 pending with deep FIFOs → sources 0,0,0,1,0,0,0,1, with d0 bursts at 2-cycle spacing.
- Driver 5 alone, weight 4, with only 2 packets → 2 packets sent, burst ends on `pndng[5]`=0, no pop issued to an empty FIFO, `ptr`=6.
- `bus_rdy`=0 for 10 cycles in SEND → `bus_vld`, `bus_data` and `bus_src` stable for all 10 cycles with no `pop`; handshake on cycle 11.
- With `WRR_STARVE_EN`, `starve_lim`=8, d0 weight 15 and always pending, d3 pending → d3 is granted before d0's burst reaches 15 packets, and the d3 grant is a single packet. Mid-SEND `reset` → `bus_vld`=0 on the next cycle.

Source files
------------

// File: rtl/bus_wrr_scheduler.sv
// Weighted round-robin bus scheduler: pops one source FIFO and holds its packet on a valid/ready port.
// Optional starvation override is built when WRR_STARVE_EN is defined.
module bus_wrr_scheduler #(
  parameter int unsigned drvrs      = 8,
  parameter int unsigned pckg_sz    = 16,
  parameter int unsigned wgt_w      = 4,
  parameter int unsigned starve_lim = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [drvrs-1:0]              pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0] D_pop,
  input  logic [drvrs*wgt_w-1:0]        weight,
  output logic [drvrs-1:0]              pop,
  output logic [pckg_sz-1:0]            bus_data,
  output logic [$clog2(drvrs)-1:0]      bus_src,
  output logic                          bus_vld,
  input  logic                          bus_rdy,
  output logic                          busy
);
  localparam int unsigned SrcW = $clog2(drvrs);

  typedef enum logic [1:0] {StIdle, StPop, StSend} state_e;

  state_e             state_q, state_d;
  logic [SrcW-1:0]    w_q, w_d, ptr_q, ptr_d, src_q, src_d;
  logic [wgt_w-1:0]   credit_q, credit_d, credit_left, win_wgt;
  logic [drvrs-1:0]   pop_q, pop_d;
  logic [pckg_sz-1:0] data_q, data_d;
  logic [SrcW-1:0]    rr_win;
  logic               st_any, st_stop;
  logic [SrcW-1:0]    st_win;

  // First pending driver searching circularly from ptr.
  always_comb begin : rr_search
    logic            found;
    logic [SrcW-1:0] idx;
    found  = 1'b0;
    rr_win = '0;
    idx    = '0;
    for (int unsigned k = 0; k < drvrs; k++) begin
      idx = SrcW'((32'(ptr_q) + k) % drvrs);
      if (!found && pndng[idx]) begin
        found  = 1'b1;
        rr_win = idx;
      end
    end
  end

`ifdef WRR_STARVE_EN
  localparam int unsigned CntW = $clog2(starve_lim + 1);

  logic [drvrs-1:0][CntW-1:0] wait_q;
  logic [drvrs-1:0]           starving, owner;

  always_comb begin
    st_any   = 1'b0;
    st_win   = '0;
    owner    = '0;
    starving = '0;
    if (state_q != StIdle) owner[w_q] = 1'b1;
    for (int unsigned i = 0; i < drvrs; i++) begin
      starving[i] = (wait_q[i] == CntW'(starve_lim));
    end
    for (int i = int'(drvrs) - 1; i >= 0; i--) begin
      if (starving[i]) begin
        st_any = 1'b1;
        st_win = SrcW'(i);
      end
    end
  end

  assign st_stop = |(starving & ~owner);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      for (int unsigned i = 0; i < drvrs; i++) begin
        if (!pndng[i] || (state_q == StIdle && state_d == StPop && w_d == SrcW'(i))) begin
          wait_q[i] <= '0;
        end else if (!owner[i] && wait_q[i] != CntW'(starve_lim)) begin
          wait_q[i] <= wait_q[i] + CntW'(1);
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (starve_lim != 0);
  assign st_any     = 1'b0;
  assign st_win     = '0;
  assign st_stop    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    credit_left = credit_q;
    win_wgt     = '0;
    pop_d       = '0;
    data_d      = data_q;
    src_d       = src_q;
    unique case (state_q)
      StIdle: begin
        if (|pndng) begin
          state_d = StPop;
          if (st_any) begin
            w_d      = st_win;
            credit_d = wgt_w'(1);
          end else begin
            w_d      = rr_win;
            win_wgt  = weight[rr_win*wgt_w +: wgt_w];
            credit_d = (win_wgt == '0) ? wgt_w'(1) : win_wgt;
          end
          pop_d[w_d] = 1'b1;
        end
      end
      StPop: begin
        data_d  = D_pop[w_q];
        src_d   = w_q;
        state_d = StSend;
      end
      StSend: begin
        if (bus_rdy) begin
          credit_left = (credit_q != '0) ? credit_q - wgt_w'(1) : '0;
          credit_d    = credit_left;
          // pndng already reflects the pop issued in the preceding POP cycle.
          if (credit_left != '0 && pndng[w_q] && !st_stop) begin
            state_d    = StPop;
            pop_d[w_q] = 1'b1;
          end else begin
            state_d = StIdle;
            ptr_d   = (w_q == SrcW'(drvrs - 1)) ? '0 : w_q + SrcW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      w_q      <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      pop_q    <= '0;
      data_q   <= '0;
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      pop_q    <= pop_d;
      data_q   <= data_d;
      src_q    <= src_d;
    end
  end

  assign pop      = pop_q;
  assign bus_data = data_q;
  assign bus_src  = src_q;
  assign bus_vld  = (state_q == StSend);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_bus_wrr_scheduler.sv
// Bench for bus_wrr_scheduler: queue-backed FIFO model and a transaction-level WRR reference.
module tb_bus_wrr_scheduler;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int WW = 4;
`ifdef WRR_STARVE_EN
  localparam int SL = 8;
`else
  localparam int SL = 64;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         pndng;
  logic [N-1:0][DW-1:0] d_pop;
  logic [N*WW-1:0]      weight;
  logic [N-1:0]         pop;
  logic [DW-1:0]        bus_data;
  logic [2:0]           bus_src;
  logic                 bus_vld, bus_rdy, busy;

  always #5 clk = ~clk;

  bus_wrr_scheduler #(
    .drvrs(N), .pckg_sz(DW), .wgt_w(WW), .starve_lim(SL)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .weight(weight), .pop(pop),
    .bus_data(bus_data), .bus_src(bus_src), .bus_vld(bus_vld), .bus_rdy(bus_rdy), .busy(busy)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [DW-1:0] fifo [N][$];
  int wt [N];
  int m_ptr, cyc, pop_err;
  bit rdy_rand;
  int obs_src[$];
  logic [DW-1:0] obs_data[$];
  int obs_cyc[$];
  int pop_cyc[$];
  int pop_idx[$];
  int exp_src[$];
  logic [DW-1:0] exp_data[$];
  logic last_vld, last_busy;
  logic [N-1:0] last_pop;
  logic [2:0] last_src;
  logic [DW-1:0] last_data;

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (fifo[i].size() != 0);
      d_pop[i] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
      weight[i*WW +: WW] = WW'(wt[i]);
    end
  endtask

  // Observe one cycle at the negedge, then advance the FIFOs after the posedge.
  task automatic tick();
    int idx;
    @(negedge clk);
    cyc++;
    idx = -1;
    last_vld = bus_vld; last_busy = busy; last_pop = pop; last_src = bus_src; last_data = bus_data;
    if (pop != '0) begin
      if ($countones(pop) != 1) pop_err++;
      for (int i = 0; i < N; i++) begin
        if (pop[i]) begin
          idx = i;
          if (!pndng[i]) pop_err++;
        end
      end
      pop_cyc.push_back(cyc);
      pop_idx.push_back(idx);
    end
    if (bus_vld && bus_rdy) begin
      obs_src.push_back(int'(bus_src));
      obs_data.push_back(bus_data);
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (idx >= 0 && fifo[idx].size() != 0) void'(fifo[idx].pop_front());
    if (rdy_rand) bus_rdy = ($urandom_range(0, 3) != 0);
    drive_inputs();
  endtask

  task automatic clear_logs();
    obs_src.delete(); obs_data.delete(); obs_cyc.delete();
    pop_cyc.delete(); pop_idx.delete(); exp_src.delete(); exp_data.delete();
    pop_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus_rdy = 1'b0; rdy_rand = 1'b0;
    for (int i = 0; i < N; i++) begin fifo[i].delete(); wt[i] = 1; end
    drive_inputs();
    tick(); tick();
    reset = 1'b0;
    m_ptr = 0;
    clear_logs();
  endtask

  // Packet order from the arbitration rules applied to the current FIFO contents.
  task automatic build_exp();
    logic [DW-1:0] q [N][$];
    int w, cr, idx;
    bit any;
    for (int i = 0; i < N; i++) q[i] = fifo[i];
    while (1) begin
      any = 0; w = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!any && q[idx].size() != 0) begin any = 1; w = idx; end
      end
      if (!any) break;
      cr = (wt[w] == 0) ? 1 : wt[w];
      do begin
        exp_src.push_back(w);
        exp_data.push_back(q[w].pop_front());
        cr--;
      end while (cr > 0 && q[w].size() != 0);
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int b = 0;
    while (obs_src.size() < n && b < budget) begin tick(); b++; end
  endtask

  task automatic drain();
    int b = 0;
    while (busy && b < 100) begin tick(); b++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fifo[4].push_back(16'hA5C3);
    drive_inputs();
    tick(); tick(); tick();
    chk_cnt++; if (last_pop !== '0) $display("FAIL reset_pop got=%h exp=0", last_pop); else pass_cnt++;
    chk_cnt++; if (last_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", last_vld); else pass_cnt++;
    chk_cnt++; if (last_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", last_busy); else pass_cnt++;
    chk_cnt++; if (last_data !== '0) $display("FAIL reset_data got=%h exp=0", last_data); else pass_cnt++;
    chk_cnt++; if (last_src !== '0) $display("FAIL reset_src got=%0d exp=0", last_src); else pass_cnt++;
    reset = 1'b0; m_ptr = 0; clear_logs(); bus_rdy = 1'b1;
    run_until(1, 20);
    chk_cnt++; if (obs_src.size() !== 1) $display("FAIL reset_release_cnt got=%0d exp=1", obs_src.size()); else pass_cnt++;
    if (obs_src.size() > 0) begin
      chk_cnt++; if (obs_data[0] !== 16'hA5C3) $display("FAIL reset_release_data got=%h exp=a5c3", obs_data[0]); else pass_cnt++;
    end
    drain();
  endtask

  task automatic test_single();
    logic [DW-1:0] v;
    int t0;
    do_reset();
    v = DW'($urandom);
    fifo[2].push_back(v);
    drive_inputs(); bus_rdy = 1'b1;
    t0 = cyc + 1;
    run_until(1, 20);
    chk_cnt++; if (pop_cyc.size() !== 1) $display("FAIL single_popcnt got=%0d exp=1", pop_cyc.size()); else pass_cnt++;
    chk_cnt++; if (obs_src.size() !== 1) $display("FAIL single_hscnt got=%0d exp=1", obs_src.size()); else pass_cnt++;
    if (pop_cyc.size() > 0 && obs_src.size() > 0) begin
      chk_cnt++; if (pop_cyc[0] !== t0 + 1) $display("FAIL single_pop_lat got=%0d exp=%0d", pop_cyc[0], t0 + 1); else pass_cnt++;
      chk_cnt++; if (pop_idx[0] !== 2) $display("FAIL single_pop_idx got=%0d exp=2", pop_idx[0]); else pass_cnt++;
      chk_cnt++; if (obs_cyc[0] !== t0 + 2) $display("FAIL single_vld_lat got=%0d exp=%0d", obs_cyc[0], t0 + 2); else pass_cnt++;
      chk_cnt++; if (obs_src[0] !== 2) $display("FAIL single_src got=%0d exp=2", obs_src[0]); else pass_cnt++;
      chk_cnt++; if (obs_data[0] !== v) $display("FAIL single_data got=%h exp=%h", obs_data[0], v); else pass_cnt++;
    end
    drain();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", busy); else pass_cnt++;
    // ptr should now be 3, so driver 4 beats driver 1.
    clear_logs();
    fifo[1].push_back(16'h1111); fifo[4].push_back(16'h4444);
    drive_inputs();
    run_until(2, 30);
    chk_cnt++; if (obs_src.size() !== 2) $display("FAIL single_ptr_cnt got=%0d exp=2", obs_src.size()); else pass_cnt++;
    if (obs_src.size() == 2) begin
      chk_cnt++; if (obs_src[0] !== 4) $display("FAIL single_ptr_first got=%0d exp=4", obs_src[0]); else pass_cnt++;
      chk_cnt++; if (obs_src[1] !== 1) $display("FAIL single_ptr_second got=%0d exp=1", obs_src[1]); else pass_cnt++;
    end
    drain();
  endtask

  task automatic test_short_burst();
    do_reset();
    wt[5] = 4;
    fifo[5].push_back(16'h5A01); fifo[5].push_back(16'h5A02);
    drive_inputs(); bus_rdy = 1'b1;
    run_until(2, 30);
    for (int k = 0; k < 6; k++) tick();
    chk_cnt++; if (obs_src.size() !== 2) $display("FAIL burst_short_cnt got=%0d exp=2", obs_src.size()); else pass_cnt++;
    chk_cnt++; if (pop_idx.size() !== 2) $display("FAIL burst_short_pops got=%0d exp=2", pop_idx.size()); else pass_cnt++;
    chk_cnt++; if (pop_err !== 0) $display("FAIL burst_short_poperr got=%0d exp=0", pop_err); else pass_cnt++;
    clear_logs();
    fifo[0].push_back(16'h0000); fifo[6].push_back(16'h6666);
    drive_inputs();
    run_until(1, 20);
    chk_cnt++; if (obs_src.size() < 1 || obs_src[0] !== 6)
      $display("FAIL burst_short_ptr got=%0d exp=6", (obs_src.size() > 0) ? obs_src[0] : -1); else pass_cnt++;
    run_until(2, 20);
    drain();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] v;
    int b, fv;
    do_reset();
    v = DW'($urandom);
    fifo[1].push_back(v);
    drive_inputs(); bus_rdy = 1'b0;
    b = 0;
    tick();
    while (!last_vld && b < 10) begin tick(); b++; end
    chk_cnt++; if (last_vld !== 1'b1) $display("FAIL bp_vld_seen got=%b exp=1", last_vld); else pass_cnt++;
    fv = cyc;
    for (int k = 1; k < 10; k++) begin
      tick();
      chk_cnt++; if (last_vld !== 1'b1) $display("FAIL bp_hold_vld got=%b exp=1", last_vld); else pass_cnt++;
      chk_cnt++; if (last_src !== 3'd1) $display("FAIL bp_hold_src got=%0d exp=1", last_src); else pass_cnt++;
      chk_cnt++; if (last_data !== v) $display("FAIL bp_hold_data got=%h exp=%h", last_data, v); else pass_cnt++;
    end
    chk_cnt++; if (pop_idx.size() !== 1) $display("FAIL bp_no_pop got=%0d exp=1", pop_idx.size()); else pass_cnt++;
    bus_rdy = 1'b1;
    tick();
    chk_cnt++; if (obs_src.size() !== 1) $display("FAIL bp_hs_cnt got=%0d exp=1", obs_src.size()); else pass_cnt++;
    if (obs_src.size() == 1) begin
      chk_cnt++; if (obs_cyc[0] !== fv + 10) $display("FAIL bp_hs_cyc got=%0d exp=%0d", obs_cyc[0], fv + 10); else pass_cnt++;
    end
    drain();
  endtask

  task automatic compare_stream(input int budget);
    run_until(exp_src.size(), budget);
    drain();
    chk_cnt++; if (obs_src.size() !== exp_src.size())
      $display("FAIL stream_cnt got=%0d exp=%0d", obs_src.size(), exp_src.size()); else pass_cnt++;
    for (int k = 0; k < exp_src.size() && k < obs_src.size(); k++) begin
      chk_cnt++; if (obs_src[k] !== exp_src[k]) $display("FAIL stream_src[%0d] got=%0d exp=%0d", k, obs_src[k], exp_src[k]); else pass_cnt++;
      chk_cnt++; if (obs_data[k] !== exp_data[k]) $display("FAIL stream_data[%0d] got=%h exp=%h", k, obs_data[k], exp_data[k]); else pass_cnt++;
    end
    chk_cnt++; if (pop_err !== 0) $display("FAIL stream_poperr got=%0d exp=0", pop_err); else pass_cnt++;
  endtask

  task automatic test_rr_all();
    do_reset();
    for (int i = 0; i < N; i++) begin
      fifo[i].push_back(DW'($urandom)); fifo[i].push_back(DW'($urandom));
    end
    drive_inputs(); bus_rdy = 1'b1;
    build_exp();
    compare_stream(200);
    chk_cnt++; if (obs_src.size() < 9 || obs_src[7] !== 7 || obs_src[8] !== 0)
      $display("FAIL rr_wrap got=%0d exp=0", (obs_src.size() > 8) ? obs_src[8] : -1); else pass_cnt++;
    for (int k = 1; k < obs_cyc.size(); k++) begin
      chk_cnt++; if (obs_cyc[k] - obs_cyc[k-1] !== 3)
        $display("FAIL rr_spacing[%0d] got=%0d exp=3", k, obs_cyc[k] - obs_cyc[k-1]); else pass_cnt++;
    end
  endtask

  task automatic test_weighted();
    int pat [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    wt[0] = 3;
    for (int k = 0; k < 6; k++) fifo[0].push_back(DW'($urandom));
    for (int k = 0; k < 2; k++) fifo[1].push_back(DW'($urandom));
    drive_inputs(); bus_rdy = 1'b1;
    build_exp();
    compare_stream(100);
    for (int k = 0; k < 8 && k < obs_src.size(); k++) begin
      chk_cnt++; if (obs_src[k] !== pat[k]) $display("FAIL wgt_pattern[%0d] got=%0d exp=%0d", k, obs_src[k], pat[k]); else pass_cnt++;
    end
    if (obs_cyc.size() >= 3) begin
      chk_cnt++; if (obs_cyc[1] - obs_cyc[0] !== 2) $display("FAIL wgt_burst_gap1 got=%0d exp=2", obs_cyc[1] - obs_cyc[0]); else pass_cnt++;
      chk_cnt++; if (obs_cyc[2] - obs_cyc[1] !== 2) $display("FAIL wgt_burst_gap2 got=%0d exp=2", obs_cyc[2] - obs_cyc[1]); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    do_reset();
    rdy_rand = 1'b1;
    for (int it = 0; it < 6; it++) begin
      clear_logs();
      for (int i = 0; i < N; i++) begin
        wt[i] = $urandom_range(0, 15);
        for (int k = $urandom_range(0, 3); k > 0; k--) fifo[i].push_back(DW'($urandom));
      end
      drive_inputs();
      build_exp();
      compare_stream(600);
    end
    rdy_rand = 1'b0;
    bus_rdy = 1'b1;
  endtask

`ifdef WRR_STARVE_EN
  task automatic test_starve();
    int pos;
    do_reset();
    wt[0] = 15; wt[3] = 15;
    for (int k = 0; k < 30; k++) fifo[0].push_back(DW'($urandom));
    for (int k = 0; k < 3; k++) fifo[3].push_back(DW'($urandom));
    drive_inputs(); bus_rdy = 1'b1;
    run_until(16, 200);
    pos = -1;
    for (int k = obs_src.size() - 1; k >= 0; k--) if (obs_src[k] == 3) pos = k;
    chk_cnt++; if (obs_src.size() < 1 || obs_src[0] !== 0) $display("FAIL starve_first got=%0d exp=0", (obs_src.size() > 0) ? obs_src[0] : -1); else pass_cnt++;
    chk_cnt++; if (pos < 1 || pos >= 15) $display("FAIL starve_grant_pos got=%0d exp=1..14", pos); else pass_cnt++;
    chk_cnt++; if (pos < 0 || pos + 1 >= obs_src.size() || obs_src[pos+1] == 3)
      $display("FAIL starve_single got=%0d exp=not3", (pos >= 0 && pos + 1 < obs_src.size()) ? obs_src[pos+1] : -1); else pass_cnt++;
    do_reset();
  endtask
`endif

  task automatic test_reset_mid();
    int b;
    do_reset();
    fifo[2].push_back(16'hBEEF);
    drive_inputs(); bus_rdy = 1'b0;
    b = 0;
    tick();
    while (!last_vld && b < 10) begin tick(); b++; end
    chk_cnt++; if (last_vld !== 1'b1) $display("FAIL rstmid_vld_seen got=%b exp=1", last_vld); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk_cnt++; if (last_vld !== 1'b0) $display("FAIL rstmid_vld got=%b exp=0", last_vld); else pass_cnt++;
    chk_cnt++; if (last_busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", last_busy); else pass_cnt++;
    chk_cnt++; if (last_data !== '0) $display("FAIL rstmid_data got=%h exp=0", last_data); else pass_cnt++;
    bus_rdy = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk_cnt++; if (obs_src.size() !== 0) $display("FAIL rstmid_dropped got=%0d exp=0", obs_src.size()); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; bus_rdy = 1'b0; rdy_rand = 1'b0; cyc = 0; pop_err = 0; m_ptr = 0;
    pndng = '0; d_pop = '0; weight = '0;
    for (int i = 0; i < N; i++) wt[i] = 1;
    test_reset();
    test_single();
    test_short_burst();
    test_backpressure();
`ifndef WRR_STARVE_EN
    test_rr_all();
    test_weighted();
    test_random();
`else
    test_starve();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
